// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-source select arbiter: default data width,
// the source-index encoding and the tie-break helper used by the grant logic.
package mux_arb_pkg;

   // Default payload width of each source and of the output register
   localparam int MUX_ARB_WIDTH = 8;

   // Source index; the value doubles as the select of the data multiplexer
   typedef enum logic {
      SRC_D0 = 1'b0,
      SRC_D1 = 1'b1
   } src_t;

   // Pick the source to serve this cycle from the two valids.
   // A lone valid always wins. On a tie, fixed priority favours source 0,
   // otherwise the source that did not win the last accepted transfer wins.
   // With no valid at all the result is don't-care (callers gate on a valid).
   function automatic src_t pick_src(
      input logic v0,
      input logic v1,
      input src_t last_grant,
      input logic fixed_prio
   );
      if (v0 && v1) begin
         if (fixed_prio) begin
            return SRC_D0;
         end
         return (last_grant == SRC_D0) ? SRC_D1 : SRC_D0;
      end
      if (v1) begin
         return SRC_D1;
      end
      return SRC_D0;
   endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Handshake bundle for mux_sel_arbiter: two valid/ready sources, one
// valid/ready output carrying the selected word and its source index S.
//   master : the environment (sources drive data/valid, sink drives Y_ready)
//   slave  : the arbiter itself
interface mux_sel_arbiter_if #(
   parameter int WIDTH = mux_arb_pkg::MUX_ARB_WIDTH
);
   import mux_arb_pkg::*;

   // Source 0
   logic [WIDTH-1:0] D0_data;
   logic             D0_valid;
   logic             D0_ready;

   // Source 1
   logic [WIDTH-1:0] D1_data;
   logic             D1_valid;
   logic             D1_ready;

   // Output word and the index of the source it came from
   logic [WIDTH-1:0] Y_data;
   logic             Y_valid;
   logic             Y_ready;
   logic             S;

   modport master (
      output D0_data, D0_valid,
      input  D0_ready,
      output D1_data, D1_valid,
      input  D1_ready,
      input  Y_data, Y_valid, S,
      output Y_ready
   );

   modport slave (
      input  D0_data, D0_valid,
      output D0_ready,
      input  D1_data, D1_valid,
      output D1_ready,
      output Y_data, Y_valid, S,
      input  Y_ready
   );

endinterface

// File: rtl/MUX2x1.sv
// Plain combinational 2:1 multiplexer: Y = S ? D1 : D0.
// The arbiter instantiates it once per data bit to build its datapath.
module MUX2x1 #(
   parameter int WIDTH = 1
)(
   input  logic [WIDTH-1:0] D0,
   input  logic [WIDTH-1:0] D1,
   input  logic             S,
   output logic [WIDTH-1:0] Y
);

   // Select between the two inputs
   assign Y = S ? D1 : D0;

endmodule

// File: rtl/mux_sel_arbiter.sv
// Two-source valid/ready arbiter with a registered, one-deep output stage.
// A new word is accepted whenever the output register is empty or being
// drained this cycle; ties between sources are broken round-robin, or in
// favour of source 0 when MUX_ARB_FIXED_PRIO_EN is defined.
// The output register reports the source index of its word on S.
module mux_sel_arbiter
   import mux_arb_pkg::*;
#(
   parameter int WIDTH = MUX_ARB_WIDTH
)(
   input  logic             clk,
   input  logic             rst,
   mux_sel_arbiter_if.slave bus
);

`ifdef MUX_ARB_FIXED_PRIO_EN
   localparam logic FIXED_PRIO = 1'b1;
`else
   localparam logic FIXED_PRIO = 1'b0;
`endif

   // Output stage and arbitration history
   logic [WIDTH-1:0] y_data_reg;
   logic             y_valid_reg;
   src_t             s_reg;
   src_t             last_grant_reg;

   // Per-cycle arbitration results
   logic             load;
   logic             any_valid;
   logic             accept;
   src_t             grant;
   logic             grant_sel;

   // Datapath
   logic [WIDTH-1:0] d0_data;
   logic [WIDTH-1:0] d1_data;
   logic [WIDTH-1:0] sel_data;

   // Decide whether the output stage can take a word and which source gets it
   always_comb begin
      load      = !y_valid_reg || bus.Y_ready;
      any_valid = bus.D0_valid || bus.D1_valid;
      grant     = pick_src(bus.D0_valid, bus.D1_valid, last_grant_reg, FIXED_PRIO);
      // Readies are forced low during reset so nothing is consumed then
      accept    = !rst && load && any_valid;
   end

   // Exactly one source sees ready, and only when its word is really taken
   assign bus.D0_ready = accept && (grant == SRC_D0);
   assign bus.D1_ready = accept && (grant == SRC_D1);

   // Data selection: one mux cell per bit, steered by the current grant
   assign d0_data   = bus.D0_data;
   assign d1_data   = bus.D1_data;
   assign grant_sel = grant;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_mux
      MUX2x1 #(
         .WIDTH (1)
      ) u_mux (
         .D0 (d0_data[gi]),
         .D1 (d1_data[gi]),
         .S  (grant_sel),
         .Y  (sel_data[gi])
      );
   end

   // Output register: load on accept, drop valid on a drain without refill,
   // otherwise hold everything (including the round-robin history)
   always_ff @(posedge clk) begin
      if (rst) begin
         y_data_reg     <= '0;
         y_valid_reg    <= 1'b0;
         s_reg          <= SRC_D0;
         last_grant_reg <= SRC_D1;
      end else if (accept) begin
         y_data_reg     <= sel_data;
         y_valid_reg    <= 1'b1;
         s_reg          <= grant;
         last_grant_reg <= grant;
      end else if (bus.Y_ready) begin
         y_valid_reg    <= 1'b0;
      end
   end

   // Drive the registered outputs onto the bundle
   assign bus.Y_data  = y_data_reg;
   assign bus.Y_valid = y_valid_reg;
   assign bus.S       = s_reg;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: a directed vector table, a few
// hand-written multi-cycle sequences, then randomized traffic compared with
// a small transaction-level model (a queue holding at most one output word).
// Honors MUX_ARB_FIXED_PRIO_EN for the expected tie-break.
module tb_mux_sel_arbiter;
   import mux_arb_pkg::*;

   localparam int W = 8;

`ifdef MUX_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mux_sel_arbiter_if #(.WIDTH(W)) bus ();

   mux_sel_arbiter #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // One cycle of stimulus plus what must be seen before and after the edge
   typedef struct {
      logic         r;
      logic         v0;
      logic [W-1:0] d0;
      logic         v1;
      logic [W-1:0] d1;
      logic         yr;
      logic         r0;
      logic         r1;
      logic         yv;
      logic [W-1:0] yd;
      logic         s;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   int n_vec    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic v0, input logic [W-1:0] d0,
                               input logic v1, input logic [W-1:0] d1, input logic yr,
                               input logic r0, input logic r1, input logic yv,
                               input logic [W-1:0] yd, input logic s);
      vec_t v;
      v.r = r; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.yr = yr;
      v.r0 = r0; v.r1 = r1; v.yv = yv; v.yd = yd; v.s = s;
      return v;
   endfunction

   // Drive one vector, check readies mid-cycle and registered outputs after the edge
   task automatic apply_vec(input string tag, input vec_t v);
      rst          = v.r;
      bus.D0_valid = v.v0;
      bus.D0_data  = v.d0;
      bus.D1_valid = v.v1;
      bus.D1_data  = v.d1;
      bus.Y_ready  = v.yr;
      @(negedge clk);
      check($sformatf("%s#%0d D0_ready", tag, n_vec), bus.D0_ready, v.r0);
      check($sformatf("%s#%0d D1_ready", tag, n_vec), bus.D1_ready, v.r1);
      @(posedge clk);
      #1;
      check($sformatf("%s#%0d Y_valid", tag, n_vec), bus.Y_valid, v.yv);
      check($sformatf("%s#%0d Y_data", tag, n_vec), bus.Y_data, v.yd);
      check($sformatf("%s#%0d S", tag, n_vec), bus.S, v.s);
      $display("%s#%0d rst=%0b v0=%0b d0=%02h v1=%0b d1=%02h yr=%0b -> rdy=%0b%0b yv=%0b yd=%02h s=%0b",
               tag, n_vec, v.r, v.v0, v.d0, v.v1, v.d1, v.yr,
               bus.D1_ready, bus.D0_ready, bus.Y_valid, bus.Y_data, bus.S);
      n_vec++;
   endtask

   // Transaction-level reference: held word queue, last output fields, tie pointer
   typedef struct {
      logic [W-1:0] data;
      logic         src;
   } word_t;

   word_t        held[$];
   logic [W-1:0] m_yd;
   logic         m_s;
   logic         m_last;

   function automatic vec_t model_step(input logic r, input logic v0, input logic [W-1:0] d0,
                                       input logic v1, input logic [W-1:0] d1, input logic yr);
      vec_t  v;
      bit    room;
      logic  win;
      word_t w;
      room = !r && (held.size() == 0 || yr);
      if (v0 && v1) win = FIXED ? 1'b0 : !m_last;
      else          win = v1;
      v = mk(r, v0, d0, v1, d1, yr,
             room && v0 && (win == 1'b0), room && v1 && (win == 1'b1), 1'b0, '0, 1'b0);
      if (r) begin
         held.delete();
         m_yd   = '0;
         m_s    = 1'b0;
         m_last = 1'b1;
      end else begin
         if (yr && held.size() > 0) void'(held.pop_front());
         if (v.r0 || v.r1) begin
            w.data = win ? d1 : d0;
            w.src  = win;
            held.push_back(w);
            m_yd   = w.data;
            m_s    = win;
            m_last = win;
         end
      end
      v.yv = (held.size() > 0);
      v.yd = m_yd;
      v.s  = m_s;
      return v;
   endfunction

   vec_t tbl[11];

   initial begin
      logic t0, t1;
      logic [W-1:0] tie_a, tie_b;
      vec_t v;

      rst = 1'b1;
      bus.D0_valid = 1'b0; bus.D0_data = '0;
      bus.D1_valid = 1'b0; bus.D1_data = '0;
      bus.Y_ready  = 1'b0;

      // Tie outcomes: round-robin alternates starting with source 0; fixed stays on 0
      t0    = 1'b0;
      t1    = FIXED ? 1'b0 : 1'b1;
      tie_a = 8'h11;
      tie_b = FIXED ? 8'h11 : 8'h22;

      //            rst v0 d0     v1 d1     yr   r0    r1   yv yd     s
      tbl[0]  = mk(1, 1, 8'h11, 1, 8'h22, 1,   0,    0,   0, 8'h00, 0);
      tbl[1]  = mk(1, 1, 8'h11, 1, 8'h22, 1,   0,    0,   0, 8'h00, 0);
      tbl[2]  = mk(0, 1, 8'hA5, 0, 8'h00, 1,   1,    0,   1, 8'hA5, 0);
      tbl[3]  = mk(0, 0, 8'h00, 1, 8'h3C, 1,   0,    1,   1, 8'h3C, 1);
      tbl[4]  = mk(0, 0, 8'h00, 0, 8'h00, 1,   0,    0,   0, 8'h3C, 1);
      tbl[5]  = mk(0, 1, 8'h11, 1, 8'h22, 1,  !t0,  t0,   1, tie_a, t0);
      tbl[6]  = mk(0, 1, 8'h11, 1, 8'h22, 1,  !t1,  t1,   1, tie_b, t1);
      tbl[7]  = mk(0, 1, 8'h11, 1, 8'h22, 1,  !t0,  t0,   1, tie_a, t0);
      tbl[8]  = mk(0, 1, 8'h11, 1, 8'h22, 1,  !t1,  t1,   1, tie_b, t1);
      tbl[9]  = mk(0, 1, 8'h77, 0, 8'h00, 1,   1,    0,   1, 8'h77, 0);
      tbl[10] = mk(0, 0, 8'h00, 0, 8'h00, 1,   0,    0,   0, 8'h77, 0);

      for (int i = 0; i < 11; i++) apply_vec("tbl", tbl[i]);

      // Backpressure: 0x5A held for five stalled cycles while both sources wait
      apply_vec("bp", mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
      apply_vec("bp", mk(0, 1, 8'h5A, 0, 8'h00, 1, 1, 0, 1, 8'h5A, 0));
      for (int i = 0; i < 5; i++)
         apply_vec("bp", mk(0, 1, 8'h11, 1, 8'h22, 0, 0, 0, 1, 8'h5A, 0));
      // Release: next word loads on the same edge the held one drains
      apply_vec("bp", mk(0, 1, 8'h11, 1, 8'h22, 1, FIXED, !FIXED, 1,
                         FIXED ? 8'h11 : 8'h22, !FIXED));
      apply_vec("bp", mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0,
                         FIXED ? 8'h11 : 8'h22, !FIXED));

      // Reset mid-stream drops the held 0x99 and restores source-0 tie priority
      apply_vec("mrst", mk(0, 0, 8'h00, 1, 8'h99, 1, 0, 1, 1, 8'h99, 1));
      apply_vec("mrst", mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 8'h99, 1));
      apply_vec("mrst", mk(1, 1, 8'h11, 1, 8'h22, 0, 0, 0, 0, 8'h00, 0));
      apply_vec("mrst", mk(0, 1, 8'h11, 1, 8'h22, 1, 1, 0, 1, 8'h11, 0));

      // Randomized traffic against the reference model
      for (int i = 0; i < 300; i++) begin
         logic r, v0, v1, yr;
         logic [W-1:0] d0, d1;
         r  = (i < 2) || ($urandom_range(0, 39) == 0);
         v0 = $urandom_range(0, 2) != 0;
         v1 = $urandom_range(0, 2) != 0;
         yr = $urandom_range(0, 3) != 0;
         d0 = W'($urandom);
         d1 = W'($urandom);
         v  = model_step(r, v0, d0, v1, d1, yr);
         apply_vec("rnd", v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
